// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg: binary32 field widths, special constants and pipeline payload types.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fpu_pkg;

   localparam int          FP_EXP_W   = 8;
   localparam int          FP_MAN_W   = 23;
   localparam int          FP_BIAS    = 127;
   localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
   localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;

   typedef enum logic [1:0] {
      CLS_ZERO   = 2'd0,
      CLS_NORMAL = 2'd1,
      CLS_INF    = 2'd2,
      CLS_NAN    = 2'd3
   } fp_class_e;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [23:0] man;
      fp_class_e   cls;
   } fp_unpacked_t;

   typedef struct packed {
      logic        sp;
      logic [31:0] sp_val;
      logic        sign;
      logic        eff_sub;
      logic [7:0]  exp;
      logic [23:0] man_g;
      logic [26:0] man_l;
   } s1_payload_t;

   typedef struct packed {
      logic        sp;
      logic [31:0] sp_val;
      logic        sign;
      logic [7:0]  exp;
      logic [27:0] sum;
      logic [4:0]  lzc;
   } s2_payload_t;

   // Denormals classify as zero, so the hidden bit is simply exp != 0.
   function automatic fp_unpacked_t fp_unpack(input logic [31:0] v);
      fp_unpacked_t u;
      u.sign = v[31];
      u.exp  = v[30:23];
      u.man  = {(v[30:23] != 8'd0), v[22:0]};
      if (v[30:23] == 8'd0)
         u.cls = CLS_ZERO;
      else if (v[30:23] == 8'hFF)
         u.cls = (v[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
      else
         u.cls = CLS_NORMAL;
      return u;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lzc28.sv
// ----------------------------------------------------------------------------
// lzc28: combinational leading-zero count of a 28-bit word (28 when all zero).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lzc28 (
   input  logic [27:0] i_val,
   output logic [4:0]  o_cnt
);

   always_comb begin
      o_cnt = 5'd28;
      for (int i = 0; i < 28; i++) begin
         if (i_val[i]) o_cnt = 5'(27 - i);
      end
   end

endmodule

`default_nettype wire

// File: rtl/fsub_pipe.sv
// ----------------------------------------------------------------------------
// fsub_pipe: 3-stage binary32 subtractor d = s - t, RNE rounding, FTZ.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fsub_pipe
   import fpu_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   s,
   input  logic [EXP_W+MAN_W:0]   t,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   d,
   output logic                   overflow
);

   logic          w_adv;
   logic          r_v1, r_v2, r_v3;
   s1_payload_t   r_s1, w_s1;
   s2_payload_t   r_s2, w_s2;
   logic [31:0]   r_d, w_d;
   logic          r_ovf, w_ovf;

   assign w_adv     = ~r_v3 | out_ready;
   assign in_ready  = w_adv;
   assign out_valid = r_v3;
   assign d         = r_d;
   assign overflow  = r_ovf;

   // Stage 1: classify, order by magnitude, align the smaller operand.
   fp_unpacked_t  w_a, w_b, w_g, w_l;
   logic [31:0]   w_tneg;
   logic          w_swap;
   logic [7:0]    w_diff;
   logic [4:0]    w_shamt;
   logic [50:0]   w_ext;

   assign w_tneg = {~t[31], t[30:0]};
   assign w_a    = fp_unpack(s);
   assign w_b    = fp_unpack(w_tneg);

   always_comb begin
      w_s1    = '0;
      w_swap  = {w_b.exp, w_b.man} > {w_a.exp, w_a.man};
      w_g     = w_swap ? w_b : w_a;
      w_l     = w_swap ? w_a : w_b;
      w_diff  = w_g.exp - w_l.exp;
      w_shamt = (w_diff > 8'd27) ? 5'd27 : w_diff[4:0];
      w_ext   = {w_l.man, 27'd0} >> w_shamt;

      w_s1.sign    = w_g.sign;
      w_s1.eff_sub = w_a.sign ^ w_b.sign;
      w_s1.exp     = w_g.exp;
      w_s1.man_g   = w_g.man;
      w_s1.man_l   = {w_ext[50:25], |w_ext[24:0]};

      w_s1.sp = 1'b1;
      if (w_a.cls == CLS_NAN || w_b.cls == CLS_NAN)
         w_s1.sp_val = FP_QNAN;
      else if (w_a.cls == CLS_INF && w_b.cls == CLS_INF)
         w_s1.sp_val = (w_a.sign != w_b.sign) ? FP_QNAN
                     : (w_a.sign ? FP_NEG_INF : FP_POS_INF);
      else if (w_a.cls == CLS_INF)
         w_s1.sp_val = w_a.sign ? FP_NEG_INF : FP_POS_INF;
      else if (w_b.cls == CLS_INF)
         w_s1.sp_val = w_b.sign ? FP_NEG_INF : FP_POS_INF;
      else if (w_a.cls == CLS_ZERO && w_b.cls == CLS_ZERO)
         w_s1.sp_val = {w_a.sign & w_b.sign, 31'd0};
      else if (w_a.cls == CLS_ZERO)
         w_s1.sp_val = w_tneg;
      else if (w_b.cls == CLS_ZERO)
         w_s1.sp_val = s;
      else
         w_s1.sp = 1'b0;
   end

   // Stage 2: magnitude add/subtract and leading-zero count.
   logic [27:0] w_big, w_small, w_sum;
   logic [4:0]  w_lzc;

   assign w_big   = {1'b0, r_s1.man_g, 3'b000};
   assign w_small = {1'b0, r_s1.man_l};
   assign w_sum   = r_s1.eff_sub ? (w_big - w_small) : (w_big + w_small);

   lzc28 u_lzc (
      .i_val (w_sum),
      .o_cnt (w_lzc)
   );

   always_comb begin
      w_s2        = '0;
      w_s2.sp     = r_s1.sp;
      w_s2.sp_val = r_s1.sp_val;
      w_s2.sign   = r_s1.sign;
      w_s2.exp    = r_s1.exp;
      w_s2.sum    = w_sum;
      w_s2.lzc    = w_lzc;
   end

   // Stage 3: normalize so the hidden bit sits at n[26], round, pack.
   logic [4:0]  w_lsh;
   logic [26:0] w_n;
   logic [9:0]  w_e, w_e2;
   logic        w_inc;
   logic [24:0] w_m25;

   always_comb begin
      w_lsh = r_s2.lzc - 5'd1;
      if (r_s2.sum[27]) begin
         w_n = {r_s2.sum[27:2], r_s2.sum[1] | r_s2.sum[0]};
         w_e = {2'b00, r_s2.exp} + 10'd1;
      end else begin
         w_n = r_s2.sum[26:0] << w_lsh;
         w_e = {2'b00, r_s2.exp} - {5'd0, w_lsh};
      end
      w_inc  = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
      w_m25  = {1'b0, w_n[26:3]} + {24'd0, w_inc};
      w_e2   = w_e + {9'd0, w_m25[24]};

      w_ovf = 1'b0;
      if (r_s2.sp)
         w_d = r_s2.sp_val;
      else if (r_s2.sum == 28'd0)
         w_d = 32'h0000_0000;
      else if (!w_e2[9] && w_e2 >= 10'd255) begin
         w_d   = {r_s2.sign, 8'hFF, 23'd0};
         w_ovf = 1'b1;
      end else if (w_e2[9] || w_e2 == 10'd0)
         w_d = 32'h0000_0000;
      else
         w_d = {r_s2.sign, w_e2[7:0], w_m25[24] ? w_m25[23:1] : w_m25[22:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_v3  <= 1'b0;
         r_s1  <= '0;
         r_s2  <= '0;
         r_d   <= '0;
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         r_v1  <= in_valid;
         r_s1  <= w_s1;
         r_v2  <= r_v1;
         r_s2  <= w_s2;
         r_v3  <= r_v2;
         r_d   <= w_d;
         r_ovf <= w_ovf;
      end
   end

endmodule

`default_nettype wire

// File: doc/fsub_pipe.md
Name: fsub_pipe

Overview:
- Pipelined single-precision (IEEE 754 binary32) subtractor computing d = s - t.
- Forms the subtract side of the FPU, alongside the combinational adder.
- Three-stage pipeline with valid/ready handshakes on input and output, so the core issue logic can stream back-to-back operations and tolerate writeback back-pressure.
- Rounding is round-to-nearest-even. Denormals are flushed to zero.

Parameters:
- EXP_W, 8, exponent width. Fixed for binary32; present for package consistency.
- MAN_W, 23, stored mantissa width.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  operands s/t are valid this cycle
- in_ready  output  1  block accepts an operation this cycle
- s  input  32  minuend
- t  input  32  subtrahend
- out_valid  output  1  d/overflow hold a valid result
- out_ready  input  1  consumer accepts the result this cycle
- d  output  32  result s - t
- overflow  output  1  finite operands produced ±inf; qualified by out_valid

Behaviour:
- Reset: all stage valid bits are 0. out_valid=0, d=32'h0, overflow=0. in_ready=1 once rst deasserts.
- Reset is asynchronous. Asserting it mid-operation drops every in-flight operation, with no partial output.
- Pipeline advance enable: adv = ~out_valid | out_ready. in_ready = adv, which is combinational from out_valid and out_ready.
- An operation is accepted when in_valid & in_ready. All stages shift together when adv=1 and hold when adv=0. Bubbles propagate as valid=0.
- Latency: an operation accepted at cycle N presents out_valid at N+3 if not stalled. Throughput is 1 per cycle.
- Results leave in acceptance order, with no loss or duplication under any out_ready pattern.
- Operand semantics: t is negated by flipping its sign bit; the datapath is then effective add/sub on magnitudes.
- Stage 1 (unpack/align):
  - Classify each operand as zero (exp=0, any mantissa, i.e. flush-to-zero), inf, NaN, or normal.
  - Swap so |g| >= |l|.
  - Diff = exp_g - exp_l. Shift {1,man_l} right by min(diff, 27) into a 27-bit field: hidden bit, 23 mantissa bits, guard, round, and sticky as the OR of all shifted-out bits.
- Stage 2 (add/sub + LZC):
  - 28-bit add when the effective signs are equal, otherwise subtract.
  - Leading-zero count of the result, range 0..27.
- Stage 3 (normalize/round/pack):
  - Carry-out: shift right 1 with sticky merge and exp+1. Otherwise shift left by the LZC and decrement exp.
  - RNE increment when guard & (round | sticky | lsb). A mantissa carry from rounding increments exp.
  - Result exp >= 255: output {sign, 8'hFF, 0} with overflow=1.
  - Result exp <= 0 (underflow): output +0 (32'h0), overflow=0.
- Special cases, in priority order:
  - Any NaN input → 32'h7FC00000.
  - inf - inf with the same sign → 32'h7FC00000.
  - Single inf → that inf with its effective sign (t's sign inverted).
  - Exact zero result (including x - x and 0 - 0) → 32'h00000000, with one exception below.
  - (-0) - (+0) → 32'h80000000.
  - Zero operand with a normal operand → the normal operand with its effective sign, exact.
- overflow is only ever 1 for finite-operand results. It is 0 for NaN/inf inputs.

Decomposition:
- Shared package fpu_pkg holds:
  - Field widths and bias (127).
  - Canonical NaN 32'h7FC00000 and ±inf constants.
  - The operand class enum {ZERO, NORMAL, INF, NAN}.
  - A packed struct for the unpacked operand (sign, exp, 24-bit mantissa, class).
  - A pipeline-stage payload struct per stage.
- One sub-module is natural: lzc28, a combinational 28-bit leading-zero counter returning 5 bits. It is used in stage 2 and is reusable by a future fmul/itof.

Test Plan:
- 0x40400000 - 0x3F800000 (3.0-1.0), out_ready=1 → after 3 cycles d=0x40000000, overflow=0.
- 0x3F800000 - 0x3F800000 → d=0x00000000. Then 0x80000000 - 0x00000000 → d=0x80000000.
- RNE tie: 0x3F800000 - 0xB3800000 (1.0 + 2^-24) → d=0x3F800000. Then 0x3F800000 - 0x33800000 → d=0x3F7FFFFF.
- Specials:
  - 0x7F800000 - 0x7F800000 → 0x7FC00000.
  - 0x7F800001 - 0x3F800000 → 0x7FC00000.
  - 0x3F800000 - 0x7F800000 → 0xFF800000, overflow=0.
  - Denormal 0x00000001 - 0x00000000 → 0x00000000.
- Overflow: 0x7F7FFFFF - 0xFF7FFFFF → d=0x7F800000, overflow=1.
- Stall/reset sequence:
  - Stream 5 ops back-to-back and hold out_ready=0 for 4 cycles after the first result. in_ready must drop while held; all 5 results emerge in order with no duplicates.
  - Assert rst for 1 cycle with 2 ops in flight → out_valid=0 immediately and no stale result after reset release.
